// File: rtl/data_memory_lsu.sv
// data_memory_lsu: word-organised data memory with an RV32I load/store front end.
// One request in flight; response after LATENCY cycles; memory self-initialises after reset.
module data_memory_lsu #(
   parameter int DEPTH        = 32,
   parameter int LATENCY      = 1,
   parameter int INIT_PATTERN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_busy
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] init_idx_q, init_idx_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;
   logic          resp_err_q, resp_err_d;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic          legal, misalign, out_of_range, err;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   load_data;
   logic [3:0]    st_be;
   logic [31:0]   st_data;
   logic          mem_we;
   logic [AW-1:0] mem_widx;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          exec;

   assign req_ready  = (state_q == S_IDLE);
   assign init_busy  = (state_q == S_INIT);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   assign idx     = addr_q[AW+1:2];
   assign rd_word = mem[idx];
   assign exec    = (state_q == S_WAIT) && (cnt_q == 3'(LATENCY - 1));

   // Decode the captured request: legality, alignment/range errors, load extraction and store lanes
   always_comb begin
      legal        = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                          : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misalign     = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      out_of_range = |addr_q[31:AW+2];
      err          = !legal || misalign || out_of_range;

      sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
      sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      case (f3_q)
         3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, sel_byte};
         3'b101:  load_data = {16'd0, sel_half};
         default: load_data = '0;
      endcase

      case (f3_q[1:0])
         2'b00: begin
            st_be   = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = wdata_q;
         end
      endcase
   end

   // Next-state, request capture, response and memory write-port selection
   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;
      mem_widx     = init_idx_q;
      mem_wdata    = '0;
      mem_be       = 4'b1111;

      case (state_q)
         S_INIT: begin
            mem_we     = 1'b1;
            mem_wdata  = (INIT_PATTERN != 0) ? {{(30-AW){1'b0}}, init_idx_q, 2'b00} : '0;
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == AW'(DEPTH - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (exec) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = err;
               resp_rdata_d = (err || we_q) ? '0 : load_data;
               if (we_q && !err) begin
                  mem_we    = 1'b1;
                  mem_widx  = idx;
                  mem_wdata = st_data;
                  mem_be    = st_be;
               end
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // Control and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_INIT;
         init_idx_q   <= '0;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Byte-lane memory write; suppressed on a reset edge so a pending store is dropped
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed scoreboard bench for data_memory_lsu (DEPTH=32, LATENCY=3).
module tb_data_memory_lsu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        init_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   data_memory_lsu #(.DEPTH(32), .LATENCY(3), .INIT_PATTERN(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pop the scoreboard on every response handshake
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, "_rdata"}, resp_rdata, e.rdata);
            chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_ready(input string nm);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk({nm, "_resp_timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input string nm);
      exp_t e;
      wait_ready(nm);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      e.rdata = er; e.err = ee; e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_drain(nm);
   endtask

   initial begin
      int n;
      int bad;
      int k;
      exp_t e;

      // T1: reset and initialisation window
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
      rst = 1'b0;
      n = 0; bad = 0;
      while (init_busy && n < 100) begin
         if (req_ready) bad++;
         n++;
         @(negedge clk);
      end
      chk("init_cycles", 32'(n), 32'd32);
      chk("ready_during_init", 32'(bad), 32'd0);
      chk("ready_after_init", {31'd0, req_ready}, 32'd1);
      issue(1'b0, 3'b010, 32'h14, '0, 32'h0000_0014, 1'b0, "t1_lw14");

      // T2: byte store and byte loads
      issue(1'b1, 3'b000, 32'h09, 32'h0000_0080, 32'h0, 1'b0, "t2_sb09");
      issue(1'b0, 3'b010, 32'h08, '0, 32'h0000_8008, 1'b0, "t2_lw08");
      issue(1'b0, 3'b000, 32'h09, '0, 32'hFFFF_FF80, 1'b0, "t2_lb09");
      issue(1'b0, 3'b100, 32'h09, '0, 32'h0000_0080, 1'b0, "t2_lbu09");

      // T3: half store and half loads
      issue(1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 32'h0, 1'b0, "t3_sh12");
      issue(1'b0, 3'b010, 32'h10, '0, 32'hBEEF_0010, 1'b0, "t3_lw10");
      issue(1'b0, 3'b001, 32'h12, '0, 32'hFFFF_BEEF, 1'b0, "t3_lh12");
      issue(1'b0, 3'b101, 32'h12, '0, 32'h0000_BEEF, 1'b0, "t3_lhu12");

      // Last valid byte of the array
      issue(1'b1, 3'b000, 32'h7F, 32'h0000_00AA, 32'h0, 1'b0, "sb7f");
      issue(1'b0, 3'b010, 32'h7C, '0, 32'hAA00_007C, 1'b0, "lw7c");
      issue(1'b0, 3'b000, 32'h7F, '0, 32'hFFFF_FFAA, 1'b0, "lb7f");

      // T4: error cases
      issue(1'b0, 3'b010, 32'h06, '0, 32'h0, 1'b1, "t4_lw06");
      issue(1'b1, 3'b010, 32'h0D, 32'hFFFF_FFFF, 32'h0, 1'b1, "t4_sw0d");
      issue(1'b0, 3'b010, 32'h0C, '0, 32'h0000_000C, 1'b0, "t4_lw0c");
      issue(1'b0, 3'b010, 32'h80, '0, 32'h0, 1'b1, "t4_lw80");
      issue(1'b0, 3'b011, 32'h00, '0, 32'h0, 1'b1, "t4_f3_011");
      issue(1'b0, 3'b001, 32'h11, '0, 32'h0, 1'b1, "t4_lh11");
      issue(1'b1, 3'b100, 32'h04, 32'h1111_1111, 32'h0, 1'b1, "t4_st_f3_100");
      issue(1'b0, 3'b010, 32'h04, '0, 32'h0000_0004, 1'b0, "t4_lw04");

      // T5: latency, stall stability, held request after handshake
      resp_ready = 1'b0;
      wait_ready("t5");
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_valid = 1'b1;
      e.rdata = 32'h14; e.err = 1'b0; e.name = "t5_lw14";
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_addr = 32'h18;
      k = 0;
      while (k < 20 && !resp_valid) begin
         @(posedge clk);
         #1 k++;
      end
      chk("t5_latency", 32'(k), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_stall_valid", {31'd0, resp_valid}, 32'd1);
         chk("t5_stall_rdata", resp_rdata, 32'h14);
         chk("t5_stall_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      chk("t5_no_early_accept", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("t5_accept_after_hs", {31'd0, req_ready}, 32'd1);
      e.rdata = 32'h18; e.err = 1'b0; e.name = "t5_lw18";
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_drain("t5");

      // T6: reset while a store is waiting
      wait_ready("t6");
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t6_valid_after_rst", {31'd0, resp_valid}, 32'd0);
      chk("t6_init_after_rst", {31'd0, init_busy}, 32'd1);
      issue(1'b0, 3'b010, 32'h00, '0, 32'h0, 1'b0, "t6_lw00");
      issue(1'b0, 3'b010, 32'h08, '0, 32'h0000_0008, 1'b0, "t6_lw08_reinit");

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
